// File: rtl/ctrl_pipe_decoder_if.sv
// D-stage bus between the decode stage and the control-pipeline decoder.
// Handshake: the decode stage presents an instruction with in_valid; it is consumed on the
// rising edge unless stall, flush or the returned hazard_stall is high in that same cycle.
interface ctrl_pipe_decoder_if #(
    parameter int RD_W = 5
);
    logic            in_valid;
    logic [6:0]      op;
    logic [RD_W-1:0] rd;
    logic [RD_W-1:0] rs1;
    logic [RD_W-1:0] rs2;
    logic            stall;
    logic            flush;
    logic            hazard_stall;

    modport master (
        output in_valid, op, rd, rs1, rs2, stall, flush,
        input  hazard_stall
    );

    modport slave (
        input  in_valid, op, rd, rs1, rs2, stall, flush,
        output hazard_stall
    );
endinterface

// File: rtl/ctrl_pipe_decoder.sv
// Pipelined main decoder: opcode -> control word in E, then carried through STAGES-1
// further registered stages to W, with load-use hazard detection and bubble insertion.
module ctrl_pipe_decoder #(
    parameter int STAGES   = 3,
    parameter int RD_W     = 5,
    parameter bit EN_AUIPC = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    ctrl_pipe_decoder_if.slave   d_if,
    output logic                 e_valid,
    output logic                 e_reg_write,
    output logic                 e_alu_src,
    output logic                 e_alu_a_pc,
    output logic                 e_branch,
    output logic [2:0]           e_imm_src,
    output logic [1:0]           e_mem_write,
    output logic [1:0]           e_result_src,
    output logic [1:0]           e_alu_op,
    output logic [1:0]           e_j,
    output logic                 e_illegal,
    output logic [RD_W-1:0]      e_rd,
    output logic                 w_valid,
    output logic                 w_reg_write,
    output logic [1:0]           w_result_src,
    output logic [RD_W-1:0]      w_rd
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic       dec_reg_write, dec_alu_src, dec_alu_a_pc, dec_branch, dec_illegal;
    logic [2:0] dec_imm_src;
    logic [1:0] dec_mem_write, dec_result_src, dec_alu_op, dec_j;
    logic       uses_rs1, uses_rs2;

    always_comb begin
        dec_reg_write  = 1'b0;
        dec_alu_src    = 1'b0;
        dec_alu_a_pc   = 1'b0;
        dec_branch     = 1'b0;
        dec_illegal    = 1'b0;
        dec_imm_src    = 3'b000;
        dec_mem_write  = 2'b00;
        dec_result_src = 2'b00;
        dec_alu_op     = 2'b00;
        dec_j          = 2'b00;
        uses_rs1       = 1'b0;
        uses_rs2       = 1'b0;
        case (d_if.op)
            OP_LOAD: begin
                dec_reg_write  = 1'b1;
                dec_alu_src    = 1'b1;
                dec_mem_write  = 2'b01;
                dec_result_src = 2'b01;
                uses_rs1       = 1'b1;
            end
            OP_STORE: begin
                dec_imm_src   = 3'b001;
                dec_alu_src   = 1'b1;
                dec_mem_write = 2'b10;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
            end
            OP_IALU: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_alu_op    = 2'b10;
                uses_rs1      = 1'b1;
            end
            OP_R: begin
                dec_reg_write = 1'b1;
                dec_alu_op    = 2'b10;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
            end
            OP_LUI: begin
                dec_reg_write = 1'b1;
                dec_imm_src   = 3'b100;
                dec_alu_src   = 1'b1;
                dec_alu_op    = 2'b11;
            end
            OP_AUIPC: begin
                if (EN_AUIPC) begin
                    dec_reg_write = 1'b1;
                    dec_imm_src   = 3'b100;
                    dec_alu_src   = 1'b1;
                    dec_alu_a_pc  = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OP_BRANCH: begin
                dec_imm_src = 3'b010;
                dec_branch  = 1'b1;
                dec_alu_op  = 2'b01;
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
            end
            OP_JAL: begin
                dec_reg_write  = 1'b1;
                dec_imm_src    = 3'b011;
                dec_result_src = 2'b10;
                dec_j          = 2'b01;
            end
            OP_JALR: begin
                dec_reg_write  = 1'b1;
                dec_alu_src    = 1'b1;
                dec_result_src = 2'b10;
                dec_j          = 2'b10;
                uses_rs1       = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Stage-0 (E) registers
    logic            e_valid_q, e_reg_write_q, e_alu_src_q, e_alu_a_pc_q, e_branch_q, e_illegal_q;
    logic [2:0]      e_imm_src_q;
    logic [1:0]      e_mem_write_q, e_result_src_q, e_alu_op_q, e_j_q;
    logic [RD_W-1:0] e_rd_q;

    logic            e_valid_d, e_reg_write_d, e_alu_src_d, e_alu_a_pc_d, e_branch_d, e_illegal_d;
    logic [2:0]      e_imm_src_d;
    logic [1:0]      e_mem_write_d, e_result_src_d, e_alu_op_d, e_j_d;
    logic [RD_W-1:0] e_rd_d;

    logic e_is_load, hazard, accept;

    // A load in E whose rd is read by the D instruction cannot be forwarded in time.
    assign e_is_load = e_valid_q & (e_result_src_q == 2'b01) & (e_rd_q != '0);
    assign hazard    = d_if.in_valid & e_is_load &
                       ((uses_rs1 & (d_if.rs1 == e_rd_q)) | (uses_rs2 & (d_if.rs2 == e_rd_q)));
    assign d_if.hazard_stall = hazard;

    assign accept = d_if.in_valid & ~d_if.flush & ~d_if.stall & ~hazard;

    always_comb begin
        e_valid_d      = accept & ~dec_illegal;
        e_illegal_d    = accept & dec_illegal;
        e_reg_write_d  = accept & dec_reg_write;
        e_alu_src_d    = accept & dec_alu_src;
        e_alu_a_pc_d   = accept & dec_alu_a_pc;
        e_branch_d     = accept & dec_branch;
        e_imm_src_d    = accept ? dec_imm_src    : 3'b000;
        e_mem_write_d  = accept ? dec_mem_write  : 2'b00;
        e_result_src_d = accept ? dec_result_src : 2'b00;
        e_alu_op_d     = accept ? dec_alu_op     : 2'b00;
        e_j_d          = accept ? dec_j          : 2'b00;
        e_rd_d         = (accept & dec_reg_write) ? d_if.rd : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid_q      <= 1'b0;
            e_reg_write_q  <= 1'b0;
            e_alu_src_q    <= 1'b0;
            e_alu_a_pc_q   <= 1'b0;
            e_branch_q     <= 1'b0;
            e_illegal_q    <= 1'b0;
            e_imm_src_q    <= 3'b000;
            e_mem_write_q  <= 2'b00;
            e_result_src_q <= 2'b00;
            e_alu_op_q     <= 2'b00;
            e_j_q          <= 2'b00;
            e_rd_q         <= '0;
        end else begin
            e_valid_q      <= e_valid_d;
            e_reg_write_q  <= e_reg_write_d;
            e_alu_src_q    <= e_alu_src_d;
            e_alu_a_pc_q   <= e_alu_a_pc_d;
            e_branch_q     <= e_branch_d;
            e_illegal_q    <= e_illegal_d;
            e_imm_src_q    <= e_imm_src_d;
            e_mem_write_q  <= e_mem_write_d;
            e_result_src_q <= e_result_src_d;
            e_alu_op_q     <= e_alu_op_d;
            e_j_q          <= e_j_d;
            e_rd_q         <= e_rd_d;
        end
    end

    // Later stages shift every cycle; a stall only ever injects bubbles at E.
    logic [STAGES-1:1] p_valid_q, p_reg_write_q;
    logic [1:0]        p_result_src_q [STAGES-1:1];
    logic [RD_W-1:0]   p_rd_q         [STAGES-1:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid_q     <= '0;
            p_reg_write_q <= '0;
            for (int k = 1; k < STAGES; k++) begin
                p_result_src_q[k] <= 2'b00;
                p_rd_q[k]         <= '0;
            end
        end else begin
            p_valid_q[1]      <= e_valid_q;
            p_reg_write_q[1]  <= e_reg_write_q;
            p_result_src_q[1] <= e_result_src_q;
            p_rd_q[1]         <= e_rd_q;
            for (int k = 2; k < STAGES; k++) begin
                p_valid_q[k]      <= p_valid_q[k-1];
                p_reg_write_q[k]  <= p_reg_write_q[k-1];
                p_result_src_q[k] <= p_result_src_q[k-1];
                p_rd_q[k]         <= p_rd_q[k-1];
            end
        end
    end

    assign e_valid      = e_valid_q;
    assign e_reg_write  = e_reg_write_q;
    assign e_alu_src    = e_alu_src_q;
    assign e_alu_a_pc   = e_alu_a_pc_q;
    assign e_branch     = e_branch_q;
    assign e_imm_src    = e_imm_src_q;
    assign e_mem_write  = e_mem_write_q;
    assign e_result_src = e_result_src_q;
    assign e_alu_op     = e_alu_op_q;
    assign e_j          = e_j_q;
    assign e_illegal    = e_illegal_q;
    assign e_rd         = e_rd_q;

    assign w_valid      = p_valid_q[STAGES-1];
    assign w_reg_write  = p_reg_write_q[STAGES-1];
    assign w_result_src = p_result_src_q[STAGES-1];
    assign w_rd         = p_rd_q[STAGES-1];
endmodule

// File: tb/tb_ctrl_pipe_decoder.sv
// Bench for ctrl_pipe_decoder: two instances (AUIPC enabled / disabled) share one stimulus
// stream; a table-driven model predicts E and W words into queues compared after each edge.
module tb_ctrl_pipe_decoder;
    localparam int STAGES = 3;
    localparam int RD_W   = 5;
    localparam int EW     = 22;
    localparam int WW     = 9;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ctrl_pipe_decoder_if #(.RD_W(RD_W)) d0 ();
    ctrl_pipe_decoder_if #(.RD_W(RD_W)) d1 ();

    assign d1.in_valid = d0.in_valid;
    assign d1.op       = d0.op;
    assign d1.rd       = d0.rd;
    assign d1.rs1      = d0.rs1;
    assign d1.rs2      = d0.rs2;
    assign d1.stall    = d0.stall;
    assign d1.flush    = d0.flush;

    logic            e_valid [2], e_reg_write [2], e_alu_src [2], e_alu_a_pc [2], e_branch [2], e_illegal [2];
    logic [2:0]      e_imm_src [2];
    logic [1:0]      e_mem_write [2], e_result_src [2], e_alu_op [2], e_j [2];
    logic [RD_W-1:0] e_rd [2];
    logic            w_valid [2], w_reg_write [2];
    logic [1:0]      w_result_src [2];
    logic [RD_W-1:0] w_rd [2];

    ctrl_pipe_decoder #(.STAGES(STAGES), .RD_W(RD_W), .EN_AUIPC(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .d_if(d0),
        .e_valid(e_valid[0]), .e_reg_write(e_reg_write[0]), .e_alu_src(e_alu_src[0]),
        .e_alu_a_pc(e_alu_a_pc[0]), .e_branch(e_branch[0]), .e_imm_src(e_imm_src[0]),
        .e_mem_write(e_mem_write[0]), .e_result_src(e_result_src[0]), .e_alu_op(e_alu_op[0]),
        .e_j(e_j[0]), .e_illegal(e_illegal[0]), .e_rd(e_rd[0]),
        .w_valid(w_valid[0]), .w_reg_write(w_reg_write[0]), .w_result_src(w_result_src[0]),
        .w_rd(w_rd[0])
    );

    ctrl_pipe_decoder #(.STAGES(STAGES), .RD_W(RD_W), .EN_AUIPC(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .d_if(d1),
        .e_valid(e_valid[1]), .e_reg_write(e_reg_write[1]), .e_alu_src(e_alu_src[1]),
        .e_alu_a_pc(e_alu_a_pc[1]), .e_branch(e_branch[1]), .e_imm_src(e_imm_src[1]),
        .e_mem_write(e_mem_write[1]), .e_result_src(e_result_src[1]), .e_alu_op(e_alu_op[1]),
        .e_j(e_j[1]), .e_illegal(e_illegal[1]), .e_rd(e_rd[1]),
        .w_valid(w_valid[1]), .w_reg_write(w_reg_write[1]), .w_result_src(w_result_src[1]),
        .w_rd(w_rd[1])
    );

    int checks = 0;
    int errors = 0;

    logic [EW-1:0] exp_q [$];
    logic [WW-1:0] exp_wq [$];

    logic [EW-1:0] m_e [2];
    logic [WW-1:0] m_p [2][STAGES];

    // E word: {valid, reg_write, alu_src, alu_a_pc, branch, imm_src, mem_write, result_src, alu_op, j, illegal, rd}
    function automatic logic [EW-1:0] act_e(input int i);
        return {e_valid[i], e_reg_write[i], e_alu_src[i], e_alu_a_pc[i], e_branch[i], e_imm_src[i],
                e_mem_write[i], e_result_src[i], e_alu_op[i], e_j[i], e_illegal[i], e_rd[i]};
    endfunction

    function automatic logic [WW-1:0] act_w(input int i);
        return {w_valid[i], w_reg_write[i], w_result_src[i], w_rd[i]};
    endfunction

    // Returns {legal, uses_rs1, uses_rs2, RegWrite, ImmSrc, ALUSrc, ALUASrc, MemWrite, ResultSrc, Branch, ALUOp, J}
    function automatic logic [17:0] tbl(input logic [6:0] op, input bit en);
        case (op)
            OP_LOAD:   return {3'b110, 15'b1_000_1_0_01_01_0_00_00};
            OP_STORE:  return {3'b111, 15'b0_001_1_0_10_00_0_00_00};
            OP_IALU:   return {3'b110, 15'b1_000_1_0_00_00_0_10_00};
            OP_R:      return {3'b111, 15'b1_000_0_0_00_00_0_10_00};
            OP_LUI:    return {3'b100, 15'b1_100_1_0_00_00_0_11_00};
            OP_AUIPC:  return en ? {3'b100, 15'b1_100_1_1_00_00_0_00_00} : 18'd0;
            OP_BRANCH: return {3'b111, 15'b0_010_0_0_00_00_1_01_00};
            OP_JAL:    return {3'b100, 15'b1_011_0_0_00_10_0_00_01};
            OP_JALR:   return {3'b110, 15'b1_000_1_0_00_10_0_00_10};
            default:   return 18'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [6:0] op, input logic [RD_W-1:0] rd_,
                        input logic [RD_W-1:0] rs1_, input logic [RD_W-1:0] rs2_,
                        input logic st, input logic fl, input logic r);
        logic [17:0]   t;
        logic [14:0]   row;
        logic [EW-1:0] e, ne;
        logic          hz, hz_obs;
        d0.in_valid = v;
        d0.op       = op;
        d0.rd       = rd_;
        d0.rs1      = rs1_;
        d0.rs2      = rs2_;
        d0.stall    = st;
        d0.flush    = fl;
        rst         = r;
        #1;
        for (int i = 0; i < 2; i++) begin
            t   = tbl(op, i == 0);
            row = t[14:0];
            e   = m_e[i];
            hz  = v & e[21] & (e[11:10] == 2'b01) & (e[4:0] != 5'd0) &
                  ((t[16] & (rs1_ == e[4:0])) | (t[15] & (rs2_ == e[4:0])));
            hz_obs = (i == 0) ? d0.hazard_stall : d1.hazard_stall;
            chk($sformatf("hazard%0d", i), {31'd0, hz_obs}, {31'd0, hz});
            ne = '0;
            if (!r && v && !st && !fl && !hz) begin
                if (t[17])
                    ne = {1'b1, row[14], row[10], row[9], row[4], row[13:11], row[8:7], row[6:5],
                          row[3:2], row[1:0], 1'b0, row[14] ? rd_ : 5'd0};
                else
                    ne = 22'd1 << 5;
            end
            if (r) begin
                for (int k = 1; k < STAGES; k++) m_p[i][k] = '0;
            end else begin
                for (int k = STAGES - 1; k > 1; k--) m_p[i][k] = m_p[i][k-1];
                m_p[i][1] = {e[21], e[20], e[11:10], e[4:0]};
            end
            m_e[i] = ne;
            exp_q.push_back(ne);
            exp_wq.push_back(m_p[i][STAGES-1]);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("e_word%0d", i), {10'd0, act_e(i)}, {10'd0, exp_q.pop_front()});
            chk($sformatf("w_word%0d", i), {23'd0, act_w(i)}, {23'd0, exp_wq.pop_front()});
        end
    endtask

    task automatic idle();
        step(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [6:0] ops [10];

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_e[i] = '0;
            for (int k = 0; k < STAGES; k++) m_p[i][k] = '0;
        end
        ops = '{OP_LOAD, OP_STORE, OP_IALU, OP_R, OP_LUI, OP_AUIPC, OP_BRANCH, OP_JAL, OP_JALR, OP_BAD};
        d0.in_valid = 1'b0; d0.op = '0; d0.rd = '0; d0.rs1 = '0; d0.rs2 = '0;
        d0.stall = 1'b0; d0.flush = 1'b0; rst = 1'b1;

        // reset state
        step(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("rst_e_valid", {31'd0, e_valid[0]}, 32'd0);

        // R-type through to W
        step(1'b1, OP_R, 5'd5, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        chk("r_e_alu_op", {30'd0, e_alu_op[0]}, 32'd2);
        chk("r_e_rd", {27'd0, e_rd[0]}, 32'd5);
        idle();
        idle();
        chk("r_w_rd", {27'd0, w_rd[0]}, 32'd5);

        // load-use on rs2, then no-hazard cases
        step(1'b1, OP_LOAD, 5'd7, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, OP_R, 5'd3, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0);
        chk("lu_bubble", {31'd0, e_valid[0]}, 32'd0);
        step(1'b1, OP_R, 5'd3, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0);
        step(1'b1, OP_LOAD, 5'd0, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, OP_R, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, OP_LOAD, 5'd7, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, OP_LUI, 5'd2, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0);

        // flush coinciding with a load-use hazard
        step(1'b1, OP_LOAD, 5'd9, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, OP_R, 5'd3, 5'd9, 5'd1, 1'b0, 1'b1, 1'b0);

        // JAL accepted, following store flushed
        step(1'b1, OP_JAL, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, OP_STORE, 5'd0, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0);
        idle();
        chk("jal_w_rs", {30'd0, w_result_src[0]}, 32'd2);

        // AUIPC enabled vs disabled, illegal opcode, stall
        step(1'b1, OP_AUIPC, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("auipc_a_pc", {31'd0, e_alu_a_pc[0]}, 32'd1);
        chk("auipc_dis_ill", {31'd0, e_illegal[1]}, 32'd1);
        step(1'b1, OP_BAD, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, OP_R, 5'd6, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);

        // reset mid-stream, then a fresh instruction
        step(1'b1, OP_IALU, 5'd10, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, OP_IALU, 5'd11, 5'd1, 5'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, OP_JALR, 5'd12, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0);
        idle();
        idle();

        // randomised traffic
        for (int n = 0; n < 60; n++) begin
            step($urandom_range(3, 0) != 0,
                 ($urandom_range(9, 0) == 0) ? 7'($urandom_range(127, 0)) : ops[$urandom_range(9, 0)],
                 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
                 $urandom_range(7, 0) == 0, $urandom_range(7, 0) == 0, $urandom_range(31, 0) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
